// File: rtl/counter_cmd_ctrl.sv
// Button front end for an up/down/load counter: synchronise, debounce, edge-detect, auto-repeat.
// Pulses are registered and appear DB_CYCLES+3 edges after a clean raw change; no backpressure.
module counter_cmd_ctrl #(
    parameter logic [15:0] DB_CYCLES = 16'd1000,
    parameter logic [15:0] RPT_DELAY = 16'd5000,
    parameter logic [15:0] RPT_RATE  = 16'd1000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_LOAD,
    input  logic [4:0] LOAD_VAL,
    input  logic       High,
    input  logic       Low,
    output logic       Load,
    output logic       Up,
    output logic       Down,
    output logic [4:0] IN
);

    localparam int B_UP = 0;
    localparam int B_DN = 1;
    localparam int B_LD = 2;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic [2:0]  w_btn_raw;
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_deb;
    logic [2:0]  r_deb_d;
    logic [2:0]  w_rise;
    logic [15:0] r_db_cnt [3];

    state_t      r_state;
    dir_t        r_dir;
    logic [15:0] r_timer;
    logic [15:0] w_limit;
    logic        w_dir_held;
    logic        w_opp_held;
    logic        w_abort;

    logic        r_load;
    logic        r_up;
    logic        r_down;
    logic [4:0]  r_in;

    assign w_btn_raw = {BTN_LOAD, BTN_DOWN, BTN_UP};
    assign w_rise    = r_deb & ~r_deb_d;

    // Debounced level flips only after DB_CYCLES+1 consecutive mismatching edges.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_db_cnt[i] == DB_CYCLES) begin
                        r_deb[i]    <= ~r_deb[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_dir_held = (r_dir == DIR_UP) ? r_deb[B_UP] : r_deb[B_DN];
    assign w_opp_held = (r_dir == DIR_UP) ? r_deb[B_DN] : r_deb[B_UP];
    assign w_abort    = !w_dir_held || w_opp_held;
    assign w_limit    = (r_state == HOLD) ? (RPT_DELAY - 16'd1) : (RPT_RATE - 16'd1);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_dir   <= DIR_UP;
            r_timer <= '0;
            r_load  <= 1'b0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_in    <= '0;
        end else begin
            r_load <= 1'b0;
            r_up   <= 1'b0;
            r_down <= 1'b0;
            if (w_rise[B_LD]) begin
                r_load  <= 1'b1;
                r_in    <= LOAD_VAL;
                r_state <= IDLE;
                r_timer <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise[B_UP] && !r_deb[B_DN]) begin
                            r_up    <= !High;
                            r_dir   <= DIR_UP;
                            r_timer <= '0;
                            r_state <= HOLD;
                        end else if (w_rise[B_DN] && !r_deb[B_UP]) begin
                            r_down  <= !Low;
                            r_dir   <= DIR_DOWN;
                            r_timer <= '0;
                            r_state <= HOLD;
                        end
                    end
                    HOLD, REPEAT: begin
                        if (w_abort) begin
                            r_state <= IDLE;
                            r_timer <= '0;
                        end else if (r_timer == w_limit) begin
                            // A saturated-masked step still advances the schedule.
                            r_up    <= (r_dir == DIR_UP) && !High;
                            r_down  <= (r_dir == DIR_DOWN) && !Low;
                            r_timer <= '0;
                            r_state <= REPEAT;
                        end else begin
                            r_timer <= r_timer + 16'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_timer <= '0;
                    end
                endcase
            end
        end
    end

    assign Load = r_load;
    assign Up   = r_up;
    assign Down = r_down;
    assign IN   = r_in;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Bench for counter_cmd_ctrl: directed scenarios plus random button traffic against a press-timeline model.
module tb_counter_cmd_ctrl;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RR = 3;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       BTN_UP, BTN_DOWN, BTN_LOAD;
    logic [4:0] LOAD_VAL;
    logic       High, Low;
    logic       Load, Up, Down;
    logic [4:0] IN;

    int n_tests = 0;
    int n_fail  = 0;

    counter_cmd_ctrl #(
        .DB_CYCLES(16'(DB)),
        .RPT_DELAY(16'(RD)),
        .RPT_RATE (16'(RR))
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .BTN_UP  (BTN_UP),
        .BTN_DOWN(BTN_DOWN),
        .BTN_LOAD(BTN_LOAD),
        .LOAD_VAL(LOAD_VAL),
        .High    (High),
        .Low     (Low),
        .Load    (Load),
        .Up      (Up),
        .Down    (Down),
        .IN      (IN)
    );

    always #5 CLK = ~CLK;

    // Reference: two-sample delay line, run-length filter, and a press timeline
    // where steps fire at elapsed 0, RD, RD+RR, RD+2RR, ... edges after the press.
    bit       m_s1 [3];
    bit       m_s2 [3];
    bit       m_deb[3];
    bit       m_debp[3];
    int       m_run[3];
    bit       m_active;
    int       m_dir;
    int       m_elapsed;
    bit       e_load, e_up, e_down;
    logic [4:0] e_in = '0;

    task automatic tick();
        bit raw[3];
        bit rise[3];
        bit fire;
        @(posedge CLK);
        raw[0] = BTN_UP;
        raw[1] = BTN_DOWN;
        raw[2] = BTN_LOAD;
        if (!RST_N) begin
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_debp[i] = 0; m_run[i] = 0;
            end
            m_active = 0; m_dir = 0; m_elapsed = 0;
            e_load = 0; e_up = 0; e_down = 0; e_in = '0;
        end else begin
            for (int i = 0; i < 3; i++) rise[i] = m_deb[i] && !m_debp[i];
            e_load = 0; e_up = 0; e_down = 0;
            if (rise[2]) begin
                e_load = 1; e_in = LOAD_VAL; m_active = 0;
            end else if (m_active) begin
                if (!m_deb[m_dir] || m_deb[1 - m_dir]) begin
                    m_active = 0;
                end else begin
                    m_elapsed++;
                    fire = (m_elapsed == RD) || (m_elapsed > RD && (m_elapsed - RD) % RR == 0);
                    if (fire && m_dir == 0) e_up = !High;
                    if (fire && m_dir == 1) e_down = !Low;
                end
            end else if (rise[0] && !m_deb[1]) begin
                m_active = 1; m_dir = 0; m_elapsed = 0; e_up = !High;
            end else if (rise[1] && !m_deb[0]) begin
                m_active = 1; m_dir = 1; m_elapsed = 0; e_down = !Low;
            end
            for (int i = 0; i < 3; i++) begin
                m_debp[i] = m_deb[i];
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB + 1) begin
                        m_deb[i] = !m_deb[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
        #1;
    endtask

    task automatic do_reset();
        RST_N = 0; BTN_UP = 0; BTN_DOWN = 0; BTN_LOAD = 0; High = 0; Low = 0;
        tick();
        tick();
        RST_N = 1;
    endtask

    task automatic test_reset();
        RST_N = 0; BTN_UP = 1; BTN_DOWN = 1; BTN_LOAD = 1; LOAD_VAL = 5'b11111;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if ({Load, Up, Down, IN} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset k=%0d: L/U/D/IN=%b%b%b/%b, want 000/00000", k, Load, Up, Down, IN);
            end
        end
    endtask

    task automatic test_clean_press();
        bit exp_up;
        do_reset();
        BTN_UP = 1;
        for (int k = 0; k < 15; k++) begin
            tick();
            exp_up = (k == 7);
            n_tests++;
            if (Up !== exp_up || Down !== 1'b0 || Load !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_press k=%0d: U/D/L=%b%b%b, want %b00", k, Up, Down, Load, exp_up);
            end
            n_tests++;
            if ({Load, Up, Down, IN} !== {e_load, e_up, e_down, e_in}) begin
                n_fail++;
                $display("FAIL clean_press_model k=%0d: got %b%b%b/%b want %b%b%b/%b",
                         k, Load, Up, Down, IN, e_load, e_up, e_down, e_in);
            end
        end
        BTN_UP = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_tests++;
            if ({Load, Up, Down, IN} !== {e_load, e_up, e_down, e_in}) begin
                n_fail++;
                $display("FAIL clean_release k=%0d: got %b%b%b/%b want %b%b%b/%b",
                         k, Load, Up, Down, IN, e_load, e_up, e_down, e_in);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            BTN_UP = (k < 20) ? 1'(k / 2 % 2 == 0) : 1'b0;
            tick();
            n_tests++;
            if ({Load, Up, Down} !== 3'b000) begin
                n_fail++;
                $display("FAIL bounce k=%0d: L/U/D=%b%b%b, want 000", k, Load, Up, Down);
            end
        end
    endtask

    task automatic test_down_repeat();
        bit exp_dn;
        do_reset();
        BTN_DOWN = 1;
        for (int k = 0; k < 60; k++) begin
            if (k == 40) BTN_DOWN = 0;
            tick();
            exp_dn = (k == 7) || (k >= 15 && k <= 46 && (k - 15) % 3 == 0);
            n_tests++;
            if (Down !== exp_dn || Up !== 1'b0 || Load !== 1'b0) begin
                n_fail++;
                $display("FAIL down_repeat k=%0d: D/U/L=%b%b%b, want %b00", k, Down, Up, Load, exp_dn);
            end
            n_tests++;
            if ({Load, Up, Down, IN} !== {e_load, e_up, e_down, e_in}) begin
                n_fail++;
                $display("FAIL down_repeat_model k=%0d: got %b%b%b/%b want %b%b%b/%b",
                         k, Load, Up, Down, IN, e_load, e_up, e_down, e_in);
            end
        end
    endtask

    task automatic test_high_mask();
        bit exp_up;
        do_reset();
        High = 1;
        BTN_UP = 1;
        for (int k = 0; k < 30; k++) begin
            if (k == 20) High = 0;
            tick();
            exp_up = (k == 21) || (k == 24) || (k == 27);
            n_tests++;
            if (Up !== exp_up) begin
                n_fail++;
                $display("FAIL high_mask k=%0d: Up=%b, want %b", k, Up, exp_up);
            end
            n_tests++;
            if ({Load, Up, Down, IN} !== {e_load, e_up, e_down, e_in}) begin
                n_fail++;
                $display("FAIL high_mask_model k=%0d: got %b%b%b/%b want %b%b%b/%b",
                         k, Load, Up, Down, IN, e_load, e_up, e_down, e_in);
            end
        end
        BTN_UP = 0;
    endtask

    task automatic test_load_during_repeat();
        bit exp_up, exp_ld;
        do_reset();
        LOAD_VAL = 5'b10110;
        BTN_UP = 1;
        for (int k = 0; k < 55; k++) begin
            if (k == 20) BTN_LOAD = 1;
            if (k == 35) BTN_LOAD = 0;
            tick();
            exp_up = (k == 7) || (k == 15) || (k == 18) || (k == 21) || (k == 24);
            exp_ld = (k == 27);
            n_tests++;
            if (Up !== exp_up || Load !== exp_ld || Down !== 1'b0) begin
                n_fail++;
                $display("FAIL load_repeat k=%0d: U/L/D=%b%b%b, want %b%b0", k, Up, Load, Down, exp_up, exp_ld);
            end
            if (k >= 27) begin
                n_tests++;
                if (IN !== 5'b10110) begin
                    n_fail++;
                    $display("FAIL load_value k=%0d: IN=%b, want 10110", k, IN);
                end
            end
        end
        BTN_UP = 0;
        for (int k = 0; k < 10; k++) tick();
        BTN_UP = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (Up !== 1'(k == 7)) begin
                n_fail++;
                $display("FAIL load_repress k=%0d: Up=%b, want %b", k, Up, 1'(k == 7));
            end
        end
        BTN_UP = 0;
    endtask

    task automatic test_reset_mid_repeat();
        do_reset();
        BTN_DOWN = 1;
        for (int k = 0; k < 24; k++) tick();
        RST_N = 0;
        tick();
        n_tests++;
        if ({Load, Up, Down, IN} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_repeat: L/U/D/IN=%b%b%b/%b, want 000/00000", Load, Up, Down, IN);
        end
        RST_N = 1;
        for (int k = 0; k < 15; k++) begin
            tick();
            n_tests++;
            if (Down !== 1'(k == 7) || Up !== 1'b0 || Load !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_fresh k=%0d: D/U/L=%b%b%b, want %b00", k, Down, Up, Load, 1'(k == 7));
            end
        end
        BTN_DOWN = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(13) == 0) BTN_UP = ~BTN_UP;
            if ($urandom_range(15) == 0) BTN_DOWN = ~BTN_DOWN;
            if ($urandom_range(39) == 0) BTN_LOAD = ~BTN_LOAD;
            if ($urandom_range(49) == 0) High = ~High;
            if ($urandom_range(49) == 0) Low = ~Low;
            if ($urandom_range(63) == 0) LOAD_VAL = 5'($urandom);
            RST_N = ($urandom_range(799) != 0);
            tick();
            n_tests++;
            if ({Load, Up, Down, IN} !== {e_load, e_up, e_down, e_in}) begin
                n_fail++;
                $display("FAIL random k=%0d: got %b%b%b/%b want %b%b%b/%b",
                         k, Load, Up, Down, IN, e_load, e_up, e_down, e_in);
            end
            n_tests++;
            if (32'(Load) + 32'(Up) + 32'(Down) > 1) begin
                n_fail++;
                $display("FAIL onehot k=%0d: L/U/D=%b%b%b, want at most one high", k, Load, Up, Down);
            end
        end
        RST_N = 1;
    endtask

    initial begin
        RST_N = 0; BTN_UP = 0; BTN_DOWN = 0; BTN_LOAD = 0;
        LOAD_VAL = '0; High = 0; Low = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_down_repeat();
        test_high_mask();
        test_load_during_repeat();
        test_reset_mid_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_cmd_ctrl.md
COUNTER_CMD_CTRL -- requirements
Module: counter_cmd_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16'd1000: consecutive stable cycles required to accept a button level change (1..65535).
REQ-002 SHALL have parameter RPT_DELAY, default 16'd5000: cycles from first step pulse to first auto-repeat pulse (1..65535).
REQ-003 SHALL have parameter RPT_RATE, default 16'd1000: cycles between successive auto-repeat pulses (1..65535).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port BTN_UP, input, 1 bit: raw, asynchronous, bouncing up button; 1 = pressed.
REQ-007 SHALL have port BTN_DOWN, input, 1 bit: raw, asynchronous down button.
REQ-008 SHALL have port BTN_LOAD, input, 1 bit: raw, asynchronous load button.
REQ-009 SHALL have port LOAD_VAL, input, 5 bits: preset value, quasi-static.
REQ-010 SHALL have port High, input, 1 bit: counter-at-max flag fed back from the downstream counter.
REQ-011 SHALL have port Low, input, 1 bit: counter-at-zero flag fed back from the downstream counter.
REQ-012 SHALL have port Load, output, 1 bit: registered one-cycle load command.
REQ-013 SHALL have port Up, output, 1 bit: registered one-cycle increment command.
REQ-014 SHALL have port Down, output, 1 bit: registered one-cycle decrement command.
REQ-015 SHALL have port IN, output, 5 bits: registered load data; valid whenever Load=1, and held between loads.

Function
REQ-016 Each BTN_* SHALL pass through a 2-flop synchronizer before any other logic.
REQ-017 Debounce SHALL be per button: a 16-bit counter increments while the synchronized level differs from the debounced level and clears on a match. When the counter reaches DB_CYCLES, the debounced level toggles and the counter clears.
REQ-018 Latency SHALL be exact: with a raw level held steady from before edge 0, the debounced level changes at edge DB_CYCLES+2, and any resulting pulse is high during the cycle after edge DB_CYCLES+3.
REQ-019 At most one of Load, Up and Down SHALL be high in any cycle; each pulse SHALL last exactly one cycle.
REQ-020 A debounced rising edge of LOAD SHALL produce Load=1 and IN=LOAD_VAL, sampled in the same cycle; Load has priority over all other activity.
REQ-021 The repeat FSM SHALL have states IDLE, HOLD and REPEAT, a 16-bit timer, and a direction register DIR (UP/DOWN).
REQ-022 IDLE: on a debounced rising edge of exactly one of UP or DOWN, the block SHALL emit that step pulse, set DIR, clear the timer and go to HOLD. Simultaneous rising edges, or one edge while the other button is debounced-held, SHALL be ignored.
REQ-023 HOLD: the timer SHALL increment each cycle; at timer==RPT_DELAY-1 the block SHALL emit a DIR pulse, clear the timer and go to REPEAT.
REQ-024 REPEAT: the timer SHALL increment each cycle; at timer==RPT_RATE-1 the block SHALL emit a DIR pulse and clear the timer.
REQ-025 HOLD/REPEAT SHALL return to IDLE with no pulse when the DIR button is debounced-released or the opposite button becomes debounced-pressed. A Load edge SHALL also return the FSM to IDLE, and Load is emitted in that cycle.
REQ-026 Saturation masking: an Up pulse SHALL be suppressed while High=1, and a Down pulse SHALL be suppressed while Low=1. Masked pulses SHALL still clear the timer and advance the FSM exactly as if emitted.
REQ-027 After a return to IDLE, a still-held button SHALL NOT restart stepping until it is released and re-pressed (debounced).

Reset
REQ-028 While RST_N=0 at a rising CLK edge, the block SHALL clear Load, Up, Down and IN (5'b00000), the synchronizers, debounced levels, debounce counters, timer and DIR (UP), and set the FSM to IDLE.
REQ-029 Reset SHALL override all activity, including mid-pulse and mid-repeat activity; outputs SHALL be 0 in the cycle after the reset edge.
REQ-030 A button held through reset release SHALL be re-debounced from level 0 and SHALL yield a fresh pulse per REQ-018.

Verification (DB_CYCLES=4, RPT_DELAY=8, RPT_RATE=3)
REQ-031 Clean BTN_UP press held steady from edge 0 with High=0 -> Up=1 only in the cycle after edge 7; Down=0 and Load=0 throughout.
REQ-032 BTN_UP toggling every 2 cycles for 20 cycles, then stable 0 -> no pulses on any output.
REQ-033 BTN_DOWN held for 40 cycles with Low=0 -> Down pulses at first-pulse cycle t, then t+8, t+11, t+14, ...; Down pulses stop within DB_CYCLES+3 cycles of release.
REQ-034 BTN_UP held with High=1 -> Up stays 0 throughout. If High drops to 0 during REPEAT -> Up pulses resume on the next RPT_RATE boundary.
REQ-035 BTN_LOAD pressed with LOAD_VAL=5'b10110 while BTN_UP is repeating -> one Load pulse with IN=5'b10110; no Up pulse in that cycle; FSM in IDLE; no further Up pulses until BTN_UP is released and re-pressed.
REQ-036 RST_N=0 for one edge mid-REPEAT with BTN_DOWN still held -> all outputs 0 next cycle; a fresh Down pulse occurs DB_CYCLES+3 edges after reset release.
